maverickone_exe_mult_accum: RTL and testbench

Consumer side of the multiplier precompute stage: accepts the registered 16-entry multiples table (k·rs1, k = 0..15) plus rs2 and the M-extension op flags, then selects and accumulates one radix-16 digit of rs2 per cycle. It applies the signed-high corrections and returns the XLEN result to writeback through a valid/ready handshake. It sits directly downstream of the precompute pipeline inside the execute unit.

---
 rtl/maverickone_exe_mult_accum_pkg.sv | 45 ++++
 rtl/maverickone_exe_mult_accum_if.sv | 34 +++
 rtl/maverickone_exe_mult_accum_digit_sel.sv | 21 ++
 rtl/maverickone_exe_mult_accum.sv | 128 ++++++++++++
 tb/tb_maverickone_exe_mult_accum.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/maverickone_exe_mult_accum_pkg.sv
// Shared definitions for the radix-16 multiply/accumulate consumer stage.
//   XLEN          datapath width (multiple of 8)
//   MULT_ENTRY_W  width of one multiples-table entry, holds 15*(2^XLEN-1)
//   MULT_DIGITS   number of radix-16 digits in an XLEN operand
//   MULT_CNT_W    width of the digit counter (must hold MULT_DIGITS)
//   mult_acc_state_e  FSM states
//   mult_op_e         captured M-extension operation
package maverickone_exe_mult_accum_pkg;

  localparam int XLEN         = 64;
  localparam int MULT_ENTRY_W = XLEN + 4;
  localparam int MULT_DIGITS  = XLEN / 4;
  localparam int MULT_CNT_W   = $clog2(MULT_DIGITS) + 1;
  localparam int MULW_DIGITS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    CORR,
    DONE
  } mult_acc_state_e;

  typedef enum logic [2:0] {
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU,
    OP_MULW
  } mult_op_e;

  // Resolves several simultaneous op flags: MULW > MULHU > MULHSU > MULH > MUL.
  function automatic mult_op_e mult_op_decode(input logic mul, input logic mulh,
                                              input logic mulhsu, input logic mulhu,
                                              input logic mulw);
    mult_op_e op;
    op = OP_MUL;
    if (mulw)        op = OP_MULW;
    else if (mulhu)  op = OP_MULHU;
    else if (mulhsu) op = OP_MULHSU;
    else if (mulh)   op = OP_MULH;
    else if (mul)    op = OP_MUL;
    return op;
  endfunction

endpackage

// File: rtl/maverickone_exe_mult_accum_if.sv
// Handshake/operand bundle between precompute, this stage and writeback.
//   valid_i/ready_o      upstream handshake (table and operands)
//   MUL_i..MULW_i        op select flags
//   table_i              16 entries k*rs1, entry k at [k*ENTRY_W +: ENTRY_W]
//   rs2_i                multiplier operand
//   rd_o/valid_o/ready_i downstream result handshake
// Modports: master = driving side (upstream + writeback), slave = this stage.
interface maverickone_exe_mult_accum_if;
  import maverickone_exe_mult_accum_pkg::*;

  logic                         valid_i;
  logic                         ready_o;
  logic                         MUL_i;
  logic                         MULH_i;
  logic                         MULHSU_i;
  logic                         MULHU_i;
  logic                         MULW_i;
  logic [16*MULT_ENTRY_W-1:0]   table_i;
  logic [XLEN-1:0]              rs2_i;
  logic [XLEN-1:0]              rd_o;
  logic                         valid_o;
  logic                         ready_i;

  modport master (
    output valid_i, MUL_i, MULH_i, MULHSU_i, MULHU_i, MULW_i, table_i, rs2_i, ready_i,
    input  ready_o, rd_o, valid_o
  );

  modport slave (
    input  valid_i, MUL_i, MULH_i, MULHSU_i, MULHU_i, MULW_i, table_i, rs2_i, ready_i,
    output ready_o, rd_o, valid_o
  );

endinterface

// File: rtl/maverickone_exe_mult_accum_digit_sel.sv
// 16:1 selector of one multiples-table entry by the current radix-16 digit.
//   entries_i  packed table, entry k at [k*ENTRY_W +: ENTRY_W]
//   sel_i      digit (0..15)
//   entry_o    selected entry, i.e. digit*rs1
module maverickone_exe_mult_accum_digit_sel
  import maverickone_exe_mult_accum_pkg::*;
(
  input  logic [16*MULT_ENTRY_W-1:0] entries_i,
  input  logic [3:0]                 sel_i,
  output logic [MULT_ENTRY_W-1:0]    entry_o
);

  logic [MULT_ENTRY_W-1:0] entry_arr [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
    assign entry_arr[gi] = entries_i[gi*MULT_ENTRY_W +: MULT_ENTRY_W];
  end

  assign entry_o = entry_arr[sel_i];

endmodule

// File: rtl/maverickone_exe_mult_accum.sv
// Radix-16 multiply consumer: captures the precomputed multiples table and
// rs2, accumulates one rs2 digit per cycle MSB-first, applies the signed
// high-half corrections and hands the result to writeback.
//   clk_i    clock
//   arst_ni  asynchronous reset, active low
//   bus      slave side of the operand/result handshake bundle
module maverickone_exe_mult_accum
  import maverickone_exe_mult_accum_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          arst_ni,
  maverickone_exe_mult_accum_if.slave   bus
);

  localparam int ENTRY_W = MULT_ENTRY_W;

  mult_acc_state_e            state_reg, state_next;
  mult_op_e                   op_reg;
  logic [16*ENTRY_W-1:0]      table_reg;
  logic [XLEN-1:0]            rs2_reg;
  logic [XLEN-1:0]            shift_reg;
  logic [MULT_CNT_W-1:0]      count_reg;
  logic [2*XLEN-1:0]          acc_reg;
  logic [XLEN-1:0]            rd_reg;

  logic                       any_op;
  logic                       accept;
  mult_op_e                   op_sel;
  logic [ENTRY_W-1:0]         entry_sel;
  logic [XLEN-1:0]            rs1;
  logic [XLEN-1:0]            hi;
  logic [XLEN-1:0]            corr_result;

  assign any_op = bus.MUL_i | bus.MULH_i | bus.MULHSU_i | bus.MULHU_i | bus.MULW_i;
  assign accept = (state_reg == IDLE) && any_op && bus.valid_i;
  assign op_sel = mult_op_decode(bus.MUL_i, bus.MULH_i, bus.MULHSU_i, bus.MULHU_i, bus.MULW_i);

  maverickone_exe_mult_accum_digit_sel u_digit_sel (
    .entries_i (table_reg),
    .sel_i     (shift_reg[XLEN-1 -: 4]),
    .entry_o   (entry_sel)
  );

  // Entry 1 of the table is rs1 itself; no separate rs1 register is needed.
  assign rs1 = table_reg[ENTRY_W +: XLEN];
  assign hi  = acc_reg[2*XLEN-1:XLEN];

  // The accumulator holds the unsigned product; the signed variants subtract
  // the operand cross terms from the high half (mod 2^XLEN).
  always_comb begin
    corr_result = hi;
    case (op_reg)
      OP_MUL:    corr_result = acc_reg[XLEN-1:0];
      OP_MULH:   corr_result = hi - (rs1[XLEN-1] ? rs2_reg : '0)
                                  - (rs2_reg[XLEN-1] ? rs1 : '0);
      OP_MULHSU: corr_result = hi - (rs1[XLEN-1] ? rs2_reg : '0);
      OP_MULHU:  corr_result = hi;
      OP_MULW:   corr_result = {{(XLEN-32){acc_reg[31]}}, acc_reg[31:0]};
      default:   corr_result = hi;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ITER;
      ITER:    if (count_reg == MULT_CNT_W'(1)) state_next = CORR;
      CORR:    state_next = DONE;
      DONE:    if (bus.ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.ready_o = (state_reg == IDLE) && any_op;
    bus.valid_o = (state_reg == DONE);
  end

  assign bus.rd_o = rd_reg;

  // Datapath
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      op_reg    <= OP_MUL;
      table_reg <= '0;
      rs2_reg   <= '0;
      shift_reg <= '0;
      count_reg <= '0;
      acc_reg   <= '0;
      rd_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            table_reg <= bus.table_i;
            rs2_reg   <= bus.rs2_i;
            op_reg    <= op_sel;
            acc_reg   <= '0;
            if (op_sel == OP_MULW) begin
              // Only the low word participates; park it in the top digits.
              shift_reg <= {bus.rs2_i[31:0], {(XLEN-32){1'b0}}};
              count_reg <= MULT_CNT_W'(MULW_DIGITS);
            end else begin
              shift_reg <= bus.rs2_i;
              count_reg <= MULT_CNT_W'(MULT_DIGITS);
            end
          end
        end
        ITER: begin
          acc_reg   <= (acc_reg << 4) + {{(2*XLEN-ENTRY_W){1'b0}}, entry_sel};
          shift_reg <= shift_reg << 4;
          count_reg <= count_reg - MULT_CNT_W'(1);
        end
        CORR:    rd_reg <= corr_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maverickone_exe_mult_accum.sv
// Scoreboard bench for maverickone_exe_mult_accum: expected results are
// pushed when an op is handed over and popped when valid_o appears.
module tb_maverickone_exe_mult_accum;

  localparam int OP_MUL = 0, OP_MULH = 1, OP_MULHSU = 2, OP_MULHU = 3, OP_MULW = 4;
  localparam int EW = 68;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [63:0] exp_q [$];

  maverickone_exe_mult_accum_if bus ();

  maverickone_exe_mult_accum dut (
    .clk_i   (clk),
    .arst_ni (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [16*EW-1:0] make_table(input logic [63:0] a);
    logic [16*EW-1:0] t;
    for (int k = 0; k < 16; k++) t[k*EW +: EW] = EW'(k) * {4'b0, a};
    return t;
  endfunction

  function automatic logic [63:0] model(input int op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  w;
    p = '0;
    w = '0;
    case (op)
      OP_MUL:    begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
      OP_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      OP_MULHSU: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
      OP_MULHU:  begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
      default:   begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w}; end
    endcase
  endfunction

  function automatic logic [63:0] pop_exp();
    if (exp_q.size() == 0) return 64'hxxxx_xxxx_xxxx_xxxx;
    return exp_q.pop_front();
  endfunction

  task automatic set_flags(input int op, input bit en);
    bus.MUL_i    = en && (op == OP_MUL);
    bus.MULH_i   = en && (op == OP_MULH);
    bus.MULHSU_i = en && (op == OP_MULHSU);
    bus.MULHU_i  = en && (op == OP_MULHU);
    bus.MULW_i   = en && (op == OP_MULW);
  endtask

  // Presents one op, waits for the accepting edge and records its expectation.
  task automatic drive_op(input int op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    set_flags(op, 1'b1);
    bus.table_i = make_table(a);
    bus.rs2_i   = b;
    bus.valid_i = 1'b1;
    #1;
    n_vec++;
    if (bus.ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL accept_ready op=%0d: ready_o=%b required 1", op, bus.ready_o);
    end
    @(posedge clk);
    exp_q.push_back(model(op, a, b));
    #1;
    bus.valid_i = 1'b0;
    bus.table_i = make_table(64'h0123_4567_89AB_CDEF);
    bus.rs2_i   = 64'hFEDC_BA98_7654_3210;
  endtask

  // Waits (bounded) for valid_o, reporting cycles since acceptance.
  task automatic collect(output logic [63:0] rd, output int lat, output bit rdy_low);
    lat = 0;
    rdy_low = 1'b1;
    while (bus.valid_o !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.ready_o !== 1'b0) rdy_low = 1'b0;
    end
    rd = bus.rd_o;
  endtask

  task automatic run_and_check(input string name, input int op, input logic [63:0] a,
                               input logic [63:0] b, input int exp_lat);
    logic [63:0] rd, exp;
    int lat;
    bit rl;
    drive_op(op, a, b);
    collect(rd, lat, rl);
    exp = pop_exp();
    n_vec++;
    if (rd !== exp) begin
      n_err++;
      $display("FAIL %s rd: got %h required %h", name, rd, exp);
    end
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (rl !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_low: got %b required 1", name, rl);
    end
    $display("%s: op=%0d rs1=%h rs2=%h rd=%h lat=%0d", name, op, a, b, rd, lat);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_vec++;
    if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL reset valid_o: got %b required 0", bus.valid_o); end
    n_vec++;
    if (bus.rd_o !== 64'h0) begin n_err++; $display("FAIL reset rd_o: got %h required 0", bus.rd_o); end
    n_vec++;
    if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL reset ready_o: got %b required 1", bus.ready_o); end
    $display("reset: valid_o=%b rd_o=%h ready_o=%b", bus.valid_o, bus.rd_o, bus.ready_o);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    run_and_check("mul_3x5", OP_MUL, 64'd3, 64'd5, 17);
    run_and_check("mulhu_ones", OP_MULHU, '1, '1, 17);
    run_and_check("mul_ones", OP_MUL, '1, '1, 17);
  endtask

  task automatic test_signed();
    run_and_check("mulh_m1", OP_MULH, '1, '1, 17);
    run_and_check("mulhsu_m1x2", OP_MULHSU, '1, 64'd2, 17);
    run_and_check("mulh_min_x2", OP_MULH, 64'h8000_0000_0000_0000, 64'd2, 17);
  endtask

  task automatic test_mulw();
    run_and_check("mulw", OP_MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 9);
    run_and_check("mulw_hi_junk", OP_MULW, 64'hDEAD_BEEF_7FFF_FFFF, 64'd2, 9);
  endtask

  task automatic test_backpressure();
    logic [63:0] rd, exp;
    int lat;
    bit rl;
    bus.ready_i = 1'b0;
    drive_op(OP_MULHU, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    collect(rd, lat, rl);
    exp = pop_exp();
    n_vec++;
    if (rd !== exp) begin n_err++; $display("FAIL bp rd: got %h required %h", rd, exp); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL bp valid_o hold %0d: got %b required 1", i, bus.valid_o); end
      n_vec++;
      if (bus.rd_o !== rd) begin n_err++; $display("FAIL bp rd_o hold %0d: got %h required %h", i, bus.rd_o, rd); end
      n_vec++;
      if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL bp ready_o hold %0d: got %b required 0", i, bus.ready_o); end
    end
    @(negedge clk);
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL bp release valid_o: got %b required 0", bus.valid_o); end
    n_vec++;
    if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL bp release ready_o: got %b required 1", bus.ready_o); end
    $display("backpressure: rd=%h held 5 cycles, released", rd);
  endtask

  task automatic test_reset_mid();
    logic [63:0] lost;
    drive_op(OP_MUL, 64'hAAAA_5555_AAAA_5555, 64'h1111_2222_3333_4444);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    lost = pop_exp();
    n_vec++;
    if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL midrst valid_o: got %b required 0", bus.valid_o); end
    n_vec++;
    if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL midrst ready_o: got %b required 1", bus.ready_o); end
    $display("reset_mid: dropped op expecting %h", lost);
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check("mul_7x9_after_rst", OP_MUL, 64'd7, 64'd9, 17);
  endtask

  task automatic test_no_op();
    bit seen_valid;
    @(negedge clk);
    set_flags(OP_MUL, 1'b0);
    bus.valid_i = 1'b1;
    bus.table_i = make_table(64'd5);
    bus.rs2_i   = 64'd5;
    #1;
    n_vec++;
    if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL noop ready_o: got %b required 0", bus.ready_o); end
    seen_valid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.valid_o !== 1'b0) seen_valid = 1'b1;
    end
    n_vec++;
    if (seen_valid !== 1'b0) begin n_err++; $display("FAIL noop accepted: valid_o seen=%b required 0", seen_valid); end
    bus.valid_i = 1'b0;
    $display("no_op: ready_o stayed low, nothing accepted");
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b;
    int op;
    for (int i = 0; i < 6; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      op = i % 5;
      run_and_check($sformatf("b2b_%0d", i), op, a, b, (op == OP_MULW) ? 9 : 17);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.table_i = '0;
    bus.rs2_i   = '0;
    set_flags(OP_MUL, 1'b1);
    #2;
    test_reset();
    test_mul();
    test_signed();
    test_mulw();
    test_backpressure();
    test_reset_mid();
    test_no_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
